// File: rtl/char_reg_pkg.sv
// Shared types and constants for the character-image pixel streamer.
`timescale 1ns/1ps
package char_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int PIX_W     = 8;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO between the image RAM return path and the downstream handshake.
`timescale 1ns/1ps
module pix_skid_fifo #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= din;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/pixel_streamer.sv
// Streams one IMG_W x IMG_H frame from a synchronous image RAM to a valid/ready sink.
// Define PIXEL_INVERT_EN to emit 255 minus each RAM byte.
`timescale 1ns/1ps
module pixel_streamer
  import char_reg_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last
);

  localparam int                NPIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam int                ENTRY_W   = PIX_W + 2;

  function automatic logic [PIX_W-1:0] pix_map(input logic [PIX_W-1:0] b);
`ifdef PIXEL_INVERT_EN
    return 8'd255 - b;
`else
    return b;
`endif
  endfunction

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic                vld_p1;
  logic                first_p1;
  logic                last_p1;
  logic [1:0]          fifo_cnt;
  logic                fifo_vld;
  logic [ENTRY_W-1:0]  fifo_din;
  logic [ENTRY_W-1:0]  fifo_dout;
  logic                fire;
  logic                rd_issue;
  logic [2:0]          credit;

  assign fire = fifo_vld & out_ready;

  // The entry leaving this cycle is counted as free, which keeps one read per cycle in steady state.
  assign credit   = 3'(fifo_cnt) + 3'(vld_p1) - 3'(fire);
  assign rd_issue = (state == FETCH) && (credit < 3'd2);

  assign mem_rd_en = rd_issue;
  assign mem_addr  = addr;
  assign busy      = (state != IDLE);
  assign done      = fire & fifo_dout[PIX_W+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            addr  <= '0;
          end
        end
        FETCH: begin
          if (rd_issue) begin
            if (addr == LAST_ADDR) state <= DRAIN;
            else                   addr  <= addr + 1'b1;
          end
        end
        DRAIN: begin
          if (done) begin
            if (start) begin
              state <= FETCH;
              addr  <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p1: read in flight, RAM data arrives with its frame-position tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1   <= rd_issue;
      first_p1 <= (addr == '0);
      last_p1  <= (addr == LAST_ADDR);
    end
  end

  assign fifo_din = {last_p1, first_p1, pix_map(mem_rd_data)};

  pix_skid_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_p1),
    .din   (fifo_din),
    .pop   (fire),
    .dout  (fifo_dout),
    .valid (fifo_vld),
    .count (fifo_cnt)
  );

  assign out_valid = fifo_vld;
  assign out_data  = fifo_dout[PIX_W-1:0];
  assign out_first = fifo_vld & fifo_dout[PIX_W];
  assign out_last  = fifo_vld & fifo_dout[PIX_W+1];

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer: RAM model, expected-pixel queue, independent monitor.
`timescale 1ns/1ps
module tb_pixel_streamer;

  localparam int NPIX = 784;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       mem_rd_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_first;
  logic       out_last;

  logic [7:0] ram [0:1023];
  exp_t       sb [$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   xfer_cnt = 0;
  int   outst = 0;
  int   max_outst = 0;
  int   lat_start = 0;
  bit   lat_arm = 0;
  bit   rand_mode = 0;
  bit   stall_prev = 0;
  logic [7:0] held;
  logic [7:0] cap [2];
  int   cap_idx = 2;

  always #5 clk = ~clk;

  pixel_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_first   (out_first),
    .out_last    (out_last)
  );

  function automatic logic [7:0] xf(input logic [7:0] b);
`ifdef PIXEL_INVERT_EN
    return 8'd255 - b;
`else
    return b;
`endif
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      outst      = 0;
      stall_prev = 0;
    end else begin
      logic f;
      exp_t e;
      f = out_valid && out_ready;
      if (stall_prev) begin
        checks++;
        if (!out_valid || out_data !== held) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b data=%0d required valid=1 data=%0d", out_valid, out_data, held);
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      outst = outst + int'(mem_rd_en) - int'(f);
      if (outst > max_outst) max_outst = outst;
      if (done) done_cnt++;
      if (f) begin
        xfer_cnt++;
        if (out_first) cap_idx = 0;
        if (cap_idx < 2) begin
          cap[cap_idx] = out_data;
          cap_idx++;
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: data=%0d first=%0b last=%0b required no transfer", out_data, out_first, out_last);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_first !== e.f || out_last !== e.l || done !== e.l) begin
            errors++;
            $display("FAIL pixel: data=%0d first=%0b last=%0b done=%0b required data=%0d first=%0b last=%0b done=%0b",
                     out_data, out_first, out_last, done, e.d, e.f, e.l, e.l);
          end
        end
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL done_no_xfer: done=1 required 0");
      end
      if (lat_arm && cyc > lat_start && out_valid) begin
        checks++;
        lat_arm = 0;
        if (cyc - lat_start != 3) begin
          errors++;
          $display("FAIL latency: got %0d cycles required 3", cyc - lat_start);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({busy, done, mem_rd_en, mem_addr, out_data, out_valid, out_first, out_last} !== '0) begin
      errors++;
      $display("FAIL %s: busy=%0b done=%0b rd_en=%0b addr=%0d data=%0d valid=%0b first=%0b last=%0b required all 0",
               name, busy, done, mem_rd_en, mem_addr, out_data, out_valid, out_first, out_last);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) sb.push_back('{d: xf(ram[i]), f: (i == 0), l: (i == NPIX - 1)});
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    push_frame();
    xfer_cnt  = 0;
    start     = 1'b1;
    lat_start = cyc;
    lat_arm   = 1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: busy=%0b required 1", busy);
    end
  endtask

  task automatic wait_frame(input string name, input int d0, input int ndone);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_timeout: %0d pixels pending busy=%0b required 0 pending", name, sb.size(), busy);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done_cnt - d0 != ndone) begin
      errors++;
      $display("FAIL %s_end: busy=%0b dones=%0d required busy=0 dones=%0d", name, busy, done_cnt - d0, ndone);
    end
  endtask

  initial begin
    int d0;
    int n;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i % 256);
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_initial");
    rst_n = 1'b1;

    // Straight frame, ready held high
    d0 = done_cnt;
    start_frame();
    wait_frame("frame_basic", d0, 1);

    // Random backpressure
    d0 = done_cnt;
    max_outst = 0;
    rand_mode = 1;
    start_frame();
    wait_frame("frame_random", d0, 1);
    rand_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    out_ready = 1'b1;
    checks++;
    if (max_outst > 2) begin
      errors++;
      $display("FAIL outstanding: max=%0d required <=2", max_outst);
    end

    // Start pulsed mid-frame must be ignored
    d0 = done_cnt;
    start_frame();
    repeat (100) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_frame("frame_restart_ignored", d0, 1);

    // Reset at pixel 300
    d0 = done_cnt;
    start_frame();
    n = 0;
    while (xfer_cnt < 300 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    rst_n = 1'b0;
    sb.delete();
    lat_arm = 0;
    #1;
    check_reset_outputs("reset_midframe_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_midframe_held");
    rst_n = 1'b1;
    start_frame();
    wait_frame("frame_after_reset", d0, 1);

    // Start coincident with done
    d0 = done_cnt;
    start_frame();
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_wait: done=0 required 1");
    end else begin
      push_frame();
      start     = 1'b1;
      lat_start = cyc;
      lat_arm   = 1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_frame("frame_back_to_back", d0, 2);

    // Pixel mapping: RAM[0]=0, RAM[1]=200
    ram[1] = 8'd200;
    d0 = done_cnt;
    start_frame();
    wait_frame("frame_map", d0, 1);
    checks++;
`ifdef PIXEL_INVERT_EN
    if (cap[0] !== 8'd255 || cap[1] !== 8'd55) begin
      errors++;
      $display("FAIL pixel_map: got %0d,%0d required 255,55", cap[0], cap[1]);
    end
`else
    if (cap[0] !== 8'd0 || cap[1] !== 8'd200) begin
      errors++;
      $display("FAIL pixel_map: got %0d,%0d required 0,200", cap[0], cap[1]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
